// File: rtl/design_select_ctrl_if.sv
// -----------------------------------------------------------------------------
// design_select_ctrl_if
// Purpose : groups the control pins, the pad I/O and the per-design wrapper
//           signals handled by design_select_ctrl.
// Signals : des_sel[5:0], hold_reset, sync_inputs, io_in[11:0] (pad side in)
//           des_io_out[NUM_DESIGNS*12-1:0]                    (designs -> ctrl)
//           des_io_in[11:0], des_reset[NUM_DESIGNS-1:0]       (ctrl -> designs)
//           io_out[11:0], des_active, active_idx[5:0]         (ctrl -> pads)
// Modports: master = environment driving the pins and design outputs
//           slave  = the controller
// -----------------------------------------------------------------------------
interface design_select_ctrl_if #(
  parameter int NUM_DESIGNS = 8
);
  logic [5:0]                  des_sel;
  logic                        hold_reset;
  logic                        sync_inputs;
  logic [11:0]                 io_in;
  logic [NUM_DESIGNS*12-1:0]   des_io_out;
  logic [11:0]                 des_io_in;
  logic [NUM_DESIGNS-1:0]      des_reset;
  logic [11:0]                 io_out;
  logic                        des_active;
  logic [5:0]                  active_idx;

  modport master (
    output des_sel, hold_reset, sync_inputs, io_in, des_io_out,
    input  des_io_in, des_reset, io_out, des_active, active_idx
  );

  modport slave (
    input  des_sel, hold_reset, sync_inputs, io_in, des_io_out,
    output des_io_in, des_reset, io_out, des_active, active_idx
  );
endinterface

// File: rtl/design_select_ctrl.sv
// -----------------------------------------------------------------------------
// design_select_ctrl
// Purpose : shares the 12-in/12-out user pads among NUM_DESIGNS designs.
//           Synchronizes des_sel/hold_reset, debounces select changes, holds
//           the newly selected design in reset, then connects it to the pads.
// Ports   : clock, reset (async, active-high)
//           bus (design_select_ctrl_if.slave) - pins, pads, design wrappers
// -----------------------------------------------------------------------------
module design_select_ctrl #(
  parameter int NUM_DESIGNS   = 8,
  parameter int STABLE_CYCLES = 4,
  parameter int RESET_CYCLES  = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  design_select_ctrl_if.slave  bus
);

  localparam int CNT_MAX = (STABLE_CYCLES > RESET_CYCLES) ? STABLE_CYCLES : RESET_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_RESET_DES,
    S_RUN
  } state_t;

  // Synchronizers
  logic [5:0]             r_sel_s1, r_sel_s;
  logic                   r_hold_s1, r_hold_s;
  logic [11:0]            r_io_s1, r_io_s2;

  // Control state
  state_t                 r_state, w_state_nxt;
  logic [5:0]             r_cand, w_cand_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic [5:0]             r_active_idx, w_idx_nxt;
  logic [NUM_DESIGNS-1:0] r_des_reset, w_des_reset_nxt;

  logic                   w_sel_ok;
  logic [11:0]            w_slice;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sel_s1     <= '0;
      r_sel_s      <= '0;
      r_hold_s1    <= 1'b0;
      r_hold_s     <= 1'b0;
      r_io_s1      <= '0;
      r_io_s2      <= '0;
      r_state      <= S_IDLE;
      r_cand       <= '0;
      r_cnt        <= '0;
      r_active_idx <= '0;
      r_des_reset  <= '1;
    end else begin
      r_sel_s1     <= bus.des_sel;
      r_sel_s      <= r_sel_s1;
      r_hold_s1    <= bus.hold_reset;
      r_hold_s     <= r_hold_s1;
      r_io_s1      <= bus.io_in;
      r_io_s2      <= r_io_s1;
      r_state      <= w_state_nxt;
      r_cand       <= w_cand_nxt;
      r_cnt        <= w_cnt_nxt;
      r_active_idx <= w_idx_nxt;
      r_des_reset  <= w_des_reset_nxt;
    end
  end

  assign w_sel_ok = ({1'b0, r_sel_s} < 7'(NUM_DESIGNS));

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a variable unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_active_idx;

    unique case (r_state)
      S_IDLE: begin
        // Out-of-range selects park here until the pins change.
        if (w_sel_ok) begin
          w_cand_nxt  = r_sel_s;
          w_cnt_nxt   = '0;
          w_state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (r_sel_s != r_cand) begin
          // Any glitch restarts the debounce window on the new value.
          w_cand_nxt  = r_sel_s;
          w_cnt_nxt   = '0;
          w_state_nxt = w_sel_ok ? S_SETTLE : S_IDLE;
        end else if (r_cnt == CNT_W'(STABLE_CYCLES - 1)) begin
          w_idx_nxt   = r_cand;
          w_cnt_nxt   = '0;
          w_state_nxt = S_RESET_DES;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      S_RESET_DES: begin
        if (r_hold_s) begin
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_W'(RESET_CYCLES - 1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_RUN;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      S_RUN: begin
        // A select change takes priority over hold_reset.
        if (r_sel_s != r_active_idx) begin
          w_cand_nxt  = r_sel_s;
          w_cnt_nxt   = '0;
          w_state_nxt = w_sel_ok ? S_SETTLE : S_IDLE;
        end else if (r_hold_s) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_RESET_DES;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // des_reset is registered from the next state, so the selected design's
  // reset drops on the same edge that enters RUN and at most one bit is low.
  always_comb begin
    w_des_reset_nxt = '1;
    for (int k = 0; k < NUM_DESIGNS; k++) begin
      if (w_state_nxt == S_RUN && w_idx_nxt == 6'(k)) w_des_reset_nxt[k] = 1'b0;
    end
  end

  // Output mux written as a compare loop so an index never reaches past the
  // des_io_out vector.
  always_comb begin
    w_slice = '0;
    for (int k = 0; k < NUM_DESIGNS; k++) begin
      if (r_active_idx == 6'(k)) w_slice = bus.des_io_out[k*12 +: 12];
    end
  end

  assign bus.io_out     = (r_state == S_RUN) ? w_slice : 12'h000;
  assign bus.des_active = (r_state == S_RUN);
  assign bus.active_idx = r_active_idx;
  assign bus.des_reset  = r_des_reset;
  // sync_inputs is a static strap, used directly.
  assign bus.des_io_in  = bus.sync_inputs ? r_io_s2 : bus.io_in;

endmodule

// File: doc/design_select_ctrl.md
Name: design_select_ctrl

Overview:
- Controller that shares the chip-level user I/O (12 in, 12 out) among NUM_DESIGNS student designs.
- Synchronizes the external design-select and hold-reset pins and debounces design-select changes.
- Sequences a clean reset of the newly selected design and then connects it to the pads.
- Sits between the GPIO-mapped control pins (des_sel, hold_reset, sync_inputs) and the per-design wrappers.

Parameters:
- NUM_DESIGNS, 8: number of attached designs; legal des_sel values are 0..NUM_DESIGNS-1 (max 64).
- STABLE_CYCLES, 4: cycles a synchronized des_sel must stay constant before it is accepted (>=1).
- RESET_CYCLES, 8: cycles the selected design is held in reset before RUN (>=1).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- des_sel  in  6  requested design index (asynchronous pins).
- hold_reset  in  1  forces the active design into reset (asynchronous pin).
- sync_inputs  in  1  1 = io_in passes through a 2-flop synchronizer; 0 = combinational passthrough.
- io_in  in  12  pad inputs.
- des_io_out  in  NUM_DESIGNS*12  per-design outputs; design k occupies bits [12k+11:12k].
- des_io_in  out  12  broadcast inputs to all designs.
- des_reset  out  NUM_DESIGNS  per-design active-high reset, registered.
- io_out  out  12  pad outputs.
- des_active  out  1  high only in RUN.
- active_idx  out  6  index of the currently accepted design.

Behaviour:
- Reset values: state=IDLE, des_reset all 1s, des_active=0, active_idx=0, io_out=0, counters=0, synchronizer flops=0.
- des_sel and hold_reset each pass through a 2-flop synchronizer, giving sel_s and hold_s (2-cycle latency).
- io_in path:
  - sync_inputs=1: des_io_in = io_in after a 2-flop synchronizer.
  - sync_inputs=0: des_io_in = io_in combinationally.
  - sync_inputs is itself used unsynchronized; it is a static strap.
- io_out = des_io_out slice[active_idx] only when state==RUN; 0 otherwise. This is combinational from registered state and index.
- des_reset is registered:
  - RUN: bit active_idx = 0 and all other bits = 1.
  - All other states: all 1s.
- FSM:
  - IDLE:
    - If sel_s < NUM_DESIGNS: cand<=sel_s, cnt<=0, go to SETTLE.
    - Otherwise stay in IDLE; out-of-range selects park here indefinitely.
  - SETTLE:
    - If sel_s != cand: cand<=sel_s and cnt<=0. Go to IDLE if sel_s is out of range, else stay in SETTLE.
    - Else if cnt==STABLE_CYCLES-1: active_idx<=cand, cnt<=0, go to RESET_DES.
    - Else cnt<=cnt+1.
  - RESET_DES:
    - If hold_s=1: cnt<=0 and stay.
    - Else if cnt==RESET_CYCLES-1: go to RUN.
    - Else cnt<=cnt+1.
  - RUN:
    - If sel_s != active_idx: cand<=sel_s, cnt<=0, go to SETTLE, or to IDLE if sel_s is out of range.
    - Else if hold_s=1: cnt<=0, go to RESET_DES.
    - If both events occur in the same cycle, the select change wins.
- Total latency: RUN is entered on edge 3+STABLE_CYCLES+RESET_CYCLES, counting edge 1 as the first edge that samples a stable new des_sel.
- Reselecting the same index while in RUN causes no action.
- A glitch shorter than STABLE_CYCLES in SETTLE restarts the count. If the pins settle back to the old index, the old design is still re-reset.
- Asynchronous reset asserted mid-sequence returns everything to reset values immediately.
- des_reset never has more than one bit low at a time.

Test Plan:
- Power-on with des_sel=5 stable, NUM_DESIGNS=8, STABLE=4, RESET=8 -> des_reset=8'hFF until edge 15, then 8'hDF; des_active=1; io_out = des_io_out[71:60].
- In RUN on design 5, switch des_sel to 2 -> the cycle after sel_s changes: io_out=0, des_reset=8'hFF, des_active=0; 12 cycles later des_reset=8'hFB and io_out tracks design 2.
- des_sel toggles 5->3->5 with each value held 2 cycles while in SETTLE -> no RESET_DES entry until 4 stable cycles of 5; active_idx ends at 5.
- hold_reset=1 for 20 cycles while in RUN -> des_reset[5]=1 and io_out=0 throughout; RUN resumes exactly RESET_CYCLES cycles after hold_s falls.
- des_sel=9 (out of range) -> FSM stays in IDLE, des_reset=8'hFF, io_out=0; changing des_sel to 1 then follows the normal sequence.
- sync_inputs=1, io_in=12'hA5C -> des_io_in=12'hA5C after 2 edges. With sync_inputs=0 the same value appears in the same cycle. Asserting reset mid-RESET_DES clears des_active and sets des_reset to all 1s immediately, without waiting for a clock edge.
